// File: rtl/boton_acond.sv
// Pushbutton conditioner: synchronize, debounce, edge-detect and auto-repeat four buttons into command pulses.
// Latency: first pulse is high for one cycle after the (DEB_CYC+3)th edge following a clean raw press.
// Backpressure: none; en_i=0 masks pulses and parks the FSMs in IDLE while debouncing keeps running.
module boton_acond #(
  parameter int DEB_CYC = 500000,
  parameter int REP_DLY = 50000000,
  parameter int REP_PER = 10000000,
  parameter int CNT_W   = 26
) (
  input  logic       CLKNEXYS,
  input  logic       MRst,
  input  logic [3:0] btn_i,
  input  logic       en_i,
  output logic       aumC_o,
  output logic       aumf_o,
  output logic       bajaC_o,
  output logic       bajaf_o,
  output logic [3:0] btn_db_o
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REP_DLY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REP_PER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_DLY = 2'd1,
    REPEAT   = 2'd2
  } state_t;

  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       stable;
  logic [3:0]       stable_d;
  logic [3:0]       rise;
  logic [3:0]       mask;
  logic [3:0]       pulse;
  logic [CNT_W-1:0] deb_cnt [4];
  logic [CNT_W-1:0] rep_cnt [4];
  state_t           st      [4];

  // Two-flop synchronizer for the asynchronous raw buttons.
  always_ff @(posedge CLKNEXYS or negedge MRst) begin
    if (!MRst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_i;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: accept a new level after DEB_CYC consecutive differing cycles; keep a delayed copy for edge detect.
  always_ff @(posedge CLKNEXYS or negedge MRst) begin
    if (!MRst) begin
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      stable_d <= stable;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          stable[i]  <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Rising edge of the stable level and up/down pair conflict masks (both from flops, no path from btn_i).
  always_comb begin
    rise    = stable & ~stable_d;
    mask    = '0;
    mask[0] = stable[0] & stable[2];
    mask[2] = stable[0] & stable[2];
    mask[1] = stable[1] & stable[3];
    mask[3] = stable[1] & stable[3];
  end

  // Per-bit press/hold/repeat FSM; pulses are registered here and masked during a pair conflict.
  always_ff @(posedge CLKNEXYS or negedge MRst) begin
    if (!MRst) begin
      pulse <= '0;
      for (int i = 0; i < 4; i++) begin
        st[i]      <= IDLE;
        rep_cnt[i] <= '0;
      end
    end else if (!en_i) begin
      pulse <= '0;
      for (int i = 0; i < 4; i++) begin
        st[i]      <= IDLE;
        rep_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        pulse[i] <= 1'b0;
        case (st[i])
          IDLE: begin
            rep_cnt[i] <= '0;
            if (rise[i]) begin
              pulse[i] <= ~mask[i];
              st[i]    <= HOLD_DLY;
            end
          end
          HOLD_DLY: begin
            if (!stable[i]) begin
              st[i]      <= IDLE;
              rep_cnt[i] <= '0;
            end else if (rep_cnt[i] == DLY_LAST) begin
              pulse[i]   <= ~mask[i];
              rep_cnt[i] <= '0;
              st[i]      <= REPEAT;
            end else begin
              rep_cnt[i] <= rep_cnt[i] + CNT_ONE;
            end
          end
          REPEAT: begin
            if (!stable[i]) begin
              st[i]      <= IDLE;
              rep_cnt[i] <= '0;
            end else if (rep_cnt[i] == PER_LAST) begin
              pulse[i]   <= ~mask[i];
              rep_cnt[i] <= '0;
            end else begin
              rep_cnt[i] <= rep_cnt[i] + CNT_ONE;
            end
          end
          default: begin
            st[i]      <= IDLE;
            rep_cnt[i] <= '0;
          end
        endcase
      end
    end
  end

  assign aumC_o   = pulse[0];
  assign aumf_o   = pulse[1];
  assign bajaC_o  = pulse[2];
  assign bajaf_o  = pulse[3];
  assign btn_db_o = stable;

endmodule

// File: tb/tb_boton_acond.sv
// Directed bench for boton_acond with a pulse scoreboard checked every cycle.
// Inputs change just after the falling edge, so edge k after a raw change is cycle (change_cycle + k).
// Expected pulses are queued as (cycle, bit) when stimulus is applied and compared on each falling edge.
module tb_boton_acond;

  localparam int DEB_CYC = 4;
  localparam int REP_DLY = 20;
  localparam int REP_PER = 8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] btn;
  logic       aumC;
  logic       aumf;
  logic       bajaC;
  logic       bajaf;
  logic [3:0] btn_db;

  typedef struct {
    int cyc;
    int b;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   n;

  boton_acond #(
    .DEB_CYC(DEB_CYC),
    .REP_DLY(REP_DLY),
    .REP_PER(REP_PER),
    .CNT_W  (26)
  ) dut (
    .CLKNEXYS(clk),
    .MRst    (rst_n),
    .btn_i   (btn),
    .en_i    (en),
    .aumC_o  (aumC),
    .aumf_o  (aumf),
    .bajaC_o (bajaC),
    .bajaf_o (bajaf),
    .btn_db_o(btn_db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_pulse(input int c, input int b);
    exp_t e;
    e.cyc = c;
    e.b   = b;
    q.push_back(e);
  endtask

  task automatic check_db(input string tag, input logic [3:0] want);
    checks++;
    assert (btn_db === want)
    else begin
      errors++;
      $error("FAIL %s btn_db_o=%b expected %b (cycle %0d)", tag, btn_db, want, cyc);
    end
  endtask

  task automatic check_pulses_zero(input string tag);
    logic [3:0] obs;
    obs = {bajaf, bajaC, aumf, aumC};
    checks++;
    assert (obs === 4'b0000)
    else begin
      errors++;
      $error("FAIL %s pulses=%b expected 0000 (cycle %0d)", tag, obs, cyc);
    end
  endtask

  // One clock: advance on the rising edge, compare pulses against the scoreboard on the falling edge.
  task automatic step();
    logic [3:0] exp_v;
    logic [3:0] obs;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    exp_v = 4'b0000;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      if (q[0].cyc == cyc) exp_v[q[0].b] = 1'b1;
      void'(q.pop_front());
    end
    obs = {bajaf, bajaC, aumf, aumC};
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL pulses cycle %0d observed=%b expected=%b", cyc, obs, exp_v);
    end
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    btn   = 4'b0000;

    // Reset state, before any clock edge.
    #1;
    check_pulses_zero("reset_async_pulses");
    check_db("reset_async_db", 4'b0000);
    steps(3);
    rst_n = 1'b1;
    steps(3);
    check_db("idle_db", 4'b0000);

    // Clean press on aumC.
    btn[0] = 1'b1;
    n = cyc;
    expect_pulse(n + DEB_CYC + 3, 0);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == DEB_CYC + 1) check_db("clean_db_before", 4'b0000);
      if (k == DEB_CYC + 2) check_db("clean_db_on", 4'b0001);
    end
    btn[0] = 1'b0;
    steps(12);
    check_db("clean_db_off", 4'b0000);

    // Bouncing aumf never settles.
    for (int k = 0; k < 12; k++) begin
      btn[1] = ((k % 4) < 2);
      step();
      check_db("bounce_db", 4'b0000);
    end
    btn[1] = 1'b0;
    steps(10);
    check_db("bounce_db_after", 4'b0000);

    // Auto-repeat on bajaC.
    btn[2] = 1'b1;
    n = cyc;
    expect_pulse(n + 7, 2);
    expect_pulse(n + 27, 2);
    expect_pulse(n + 35, 2);
    expect_pulse(n + 43, 2);
    expect_pulse(n + 51, 2);
    expect_pulse(n + 59, 2);
    steps(60);
    check_db("repeat_db_held", 4'b0100);
    btn[2] = 1'b0;
    steps(16);
    check_db("repeat_db_off", 4'b0000);

    // aumC/bajaC pair conflict.
    btn = 4'b0101;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 10) check_db("conflict_db_mid", 4'b0101);
    end
    check_db("conflict_db_end", 4'b0101);
    btn = 4'b0000;
    steps(12);
    check_db("conflict_db_off", 4'b0000);

    // Enable low while bajaf is pressed, raised mid-hold.
    en     = 1'b0;
    btn[3] = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (k == 15) en = 1'b1;
    end
    check_db("enable_db_held", 4'b1000);
    btn[3] = 1'b0;
    steps(12);
    btn[3] = 1'b1;
    n = cyc;
    expect_pulse(n + 7, 3);
    steps(12);
    btn[3] = 1'b0;
    steps(12);
    check_db("enable_db_off", 4'b0000);

    // Reset in the middle of a bajaC hold.
    btn[2] = 1'b1;
    n = cyc;
    expect_pulse(n + 7, 2);
    steps(25);
    check_db("midhold_db_before", 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    check_pulses_zero("midhold_async_pulses");
    check_db("midhold_async_db", 4'b0000);
    q.delete();
    steps(2);
    check_db("midhold_db_in_reset", 4'b0000);
    rst_n = 1'b1;
    n = cyc;
    expect_pulse(n + DEB_CYC + 3, 2);
    steps(15);
    check_db("midhold_db_after", 4'b0100);
    btn[2] = 1'b0;
    steps(20);
    check_db("midhold_db_off", 4'b0000);

    checks++;
    assert (q.size() == 0)
    else begin
      errors++;
      $error("FAIL scoreboard_drain pending=%0d expected 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/boton_acond.md
BOTON_ACOND -- requirements
Module: boton_acond

Interface
REQ-001 Parameter DEB_CYC, default 500000: number of stable clock cycles needed to accept a button level change (5 ms at 100 MHz).
REQ-002 Parameter REP_DLY, default 50000000: hold time in cycles from the first pulse to the first auto-repeat pulse.
REQ-003 Parameter REP_PER, default 10000000: auto-repeat period in cycles.
REQ-004 Parameter CNT_W, default 26: width of every internal counter, which SHALL be able to hold max(DEB_CYC, REP_DLY, REP_PER).
REQ-005 CLKNEXYS  in  1  single system clock; all state SHALL change on its rising edge.
REQ-006 MRst  in  1  asynchronous, active-low reset.
REQ-007 btn_i  in  4  raw pushbuttons, asynchronous to the clock: [0]=aumC, [1]=aumf, [2]=bajaC, [3]=bajaf.
REQ-008 en_i  in  1  pulse-output enable.
REQ-009 aumC_o, aumf_o, bajaC_o, bajaf_o  out  1 each  registered single-cycle command pulses that drive the MisB aumC_i/aumf_i/bajaC_i/bajaf_i inputs.
REQ-010 btn_db_o  out  4  debounced button levels, with the same bit order as btn_i.

Function
REQ-011 Each btn_i bit SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-012 Each bit SHALL have its own debounce counter with the following behaviour:
- The counter increments every cycle that the synchronized value differs from the stable level.
- The counter clears whenever the two are equal.
- When the counter equals DEB_CYC-1 and the values still differ, the stable level takes the synchronized value and the counter clears.
REQ-013 btn_db_o SHALL equal the stable levels.
REQ-014 A raw level held constant SHALL cause the stable level to change on the (DEB_CYC+2)th rising edge after the raw change.
REQ-015 The matching first pulse SHALL be high for exactly one cycle after the (DEB_CYC+3)th edge.
REQ-016 Each bit SHALL have its own state machine with states IDLE, HOLD_DLY and REPEAT, plus a repeat counter.
REQ-017 In IDLE, a rising edge of the stable level SHALL issue a pulse, clear the repeat counter and move the FSM to HOLD_DLY.
REQ-018 In HOLD_DLY, the repeat counter SHALL increment each cycle.
REQ-019 In HOLD_DLY, when the repeat counter reaches REP_DLY-1, the block SHALL issue a pulse, clear the counter and move to REPEAT.
REQ-020 In REPEAT, when the repeat counter reaches REP_PER-1, the block SHALL issue a pulse and clear the counter.
REQ-021 In HOLD_DLY or REPEAT, a stable level of 0 SHALL return the FSM to IDLE with the counter cleared and no pulse; this has priority over the pulse conditions.
REQ-022 Pair conflict: while stable aumC and bajaC are both 1, aumC_o and bajaC_o SHALL be held at 0.
REQ-023 Pair conflict: while stable aumf and bajaf are both 1, aumf_o and bajaf_o SHALL be held at 0.
REQ-024 During a pair conflict the FSMs SHALL keep running; only their pulses are masked.
REQ-025 While en_i=0, all four pulse outputs SHALL be 0, all FSMs SHALL be held in IDLE, and debouncing SHALL continue.
REQ-026 After en_i returns to 1, a button that is already stable-high SHALL NOT pulse until it has been released and pressed again, because IDLE requires a rising edge.
REQ-027 The stable-level rising-edge detect SHALL be registered per bit, so that no output ever pulses on two consecutive cycles.
REQ-028 A given bit's FSM SHALL issue at most one pulse per cycle.
REQ-029 All outputs SHALL be driven from flops, with no combinational path from btn_i.

Reset
REQ-030 MRst=0 SHALL immediately force the following, regardless of the clock:
- synchronizers, stable levels and all counters to 0;
- all FSMs to IDLE;
- every output to 0.
REQ-031 On MRst deassertion, a button already held SHALL be treated as a new press and produce one pulse after the REQ-015 latency.
REQ-032 A reset asserted in the middle of a hold SHALL abort any pending repeat pulse.

Verification (bench parameters DEB_CYC=4, REP_DLY=20, REP_PER=8; edges are counted from the raw change)
REQ-033 Clean press: btn_i[0]=1 for 10 cycles, then 0 -> aumC_o high only after edge 7, no other output pulses, btn_db_o[0]=1 from edge 6.
REQ-034 Bounce: btn_i[1] toggles every 2 cycles for 12 cycles, then stays 0 -> btn_db_o[1] stays 0 and no aumf_o pulse occurs.
REQ-035 Auto-repeat: btn_i[2]=1 for 60 cycles -> bajaC_o pulses after edges 7, 27, 35, 43, 51 and 59, with none after release plus DEB_CYC+2.
REQ-036 Conflict: btn_i[0] and btn_i[2] pressed on the same cycle and held for 30 cycles -> btn_db_o=4'b0101, and aumC_o and bajaC_o stay 0.
REQ-037 Enable: en_i=0, btn_i[3] pressed; en_i is raised at cycle 15 while the button is held -> no bajaf_o pulse; release and re-press -> one pulse after edge 7 of the re-press.
REQ-038 Reset mid-hold: MRst=0 at cycle 25 of scenario REQ-035 -> all outputs go to 0 asynchronously; after release of MRst, the first pulse arrives DEB_CYC+3 edges later.
